// File: rtl/extio8x4_pkg.sv
// Shared types and constants for the extio8x4 initiator-side scheduler.
// Slot numbering, command nibbles and status bit positions live here so every file agrees.
package extio8x4_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POLL  = 3'd1,
        ARB   = 3'd2,
        WAIT  = 3'd3,
        ISSUE = 3'd4
    } state_t;

    localparam logic [1:0] SLOT_RD0 = 2'd0;
    localparam logic [1:0] SLOT_WR0 = 2'd1;
    localparam logic [1:0] SLOT_RD1 = 2'd2;
    localparam logic [1:0] SLOT_WR1 = 2'd3;

    localparam logic [3:0] CMD_RD0     = 4'b0001;
    localparam logic [3:0] CMD_WR0     = 4'b0000;
    localparam logic [3:0] CMD_RD1     = 4'b0011;
    localparam logic [3:0] CMD_WR1     = 4'b0010;
    localparam logic [3:0] CMD_INVALID = 4'b1111;

    // Target status is active-low: a 0 bit means data pending / room available
    localparam int STAT_RX0 = 0;
    localparam int STAT_TX0 = 1;
    localparam int STAT_RX1 = 2;
    localparam int STAT_TX1 = 3;

    function automatic logic [3:0] slot_cmd(input logic [1:0] k);
        logic [3:0] c;
        case (k)
            SLOT_RD0: c = CMD_RD0;
            SLOT_WR0: c = CMD_WR0;
            SLOT_RD1: c = CMD_RD1;
            default:  c = CMD_WR1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/extio8x4_rr_arb4.sv
// Combinational 4-way round-robin picker: search begins at ptr and wraps 3->0,
// the first eligible slot wins.
module extio8x4_rr_arb4 (
    input  logic [3:0] elig,
    input  logic [1:0] ptr,
    output logic       gnt_vld,
    output logic [1:0] gnt_idx
);

    logic [1:0] w_cand;

    // Walk offsets from farthest to nearest so the nearest eligible slot is the last written
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = ptr;
        w_cand  = ptr;
        for (int i = 3; i >= 0; i--) begin
            w_cand = ptr + 2'(i);
            if (elig[w_cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/extio8x4_isched.sv
// Initiator-side channel scheduler: polls target status, arbitrates four transfer
// slots round-robin and issues one command at a time, with a watchdog on both handshakes.
module extio8x4_isched
    import extio8x4_pkg::*;
#(
    parameter int POLL_GAP = 16,
    parameter int TIMEOUT  = 1024
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       en,
    input  logic       err_clr,
    output logic       stat_req,
    input  logic       stat_valid,
    input  logic [3:0] stat4,
    output logic       cmd_req,
    output logic [3:0] cmd4,
    input  logic       cmd_done,
    input  logic [1:0] loc_rx_room,
    input  logic [1:0] loc_tx_pend,
    output logic       busy,
    output logic       timeout_err
);

    localparam int WDW = $clog2(TIMEOUT);
    localparam int GW  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
    localparam logic [GW-1:0]  GAP_LOAD = GW'(POLL_GAP - 1);

    state_t           r_state;
    logic             r_stat_req;
    logic             r_cmd_req;
    logic [3:0]       r_cmd4;
    logic             r_busy;
    logic             r_timeout_err;
    logic [1:0]       r_rr_ptr;
    logic [3:0]       r_stat_q;
    logic [WDW-1:0]   r_wd_cnt;
    logic [GW-1:0]    r_gap_cnt;

    logic [3:0]       w_elig;
    logic             w_gnt_vld;
    logic [1:0]       w_gnt_idx;

    always_comb begin
        w_elig           = 4'b0000;
        w_elig[SLOT_RD0] = ~r_stat_q[STAT_RX0] & loc_rx_room[0];
        w_elig[SLOT_WR0] = ~r_stat_q[STAT_TX0] & loc_tx_pend[0];
        w_elig[SLOT_RD1] = ~r_stat_q[STAT_RX1] & loc_rx_room[1];
        w_elig[SLOT_WR1] = ~r_stat_q[STAT_TX1] & loc_tx_pend[1];
    end

    extio8x4_rr_arb4 u_arb (
        .elig    (w_elig),
        .ptr     (r_rr_ptr),
        .gnt_vld (w_gnt_vld),
        .gnt_idx (w_gnt_idx)
    );

    // A later timeout assignment overrides an earlier err_clr, so expiry wins a tie
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= IDLE;
            r_stat_req    <= 1'b0;
            r_cmd_req     <= 1'b0;
            r_cmd4        <= CMD_INVALID;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_rr_ptr      <= 2'd0;
            r_stat_q      <= 4'b1111;
            r_wd_cnt      <= '0;
            r_gap_cnt     <= '0;
        end else begin
            if (err_clr) r_timeout_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (en && !r_timeout_err) begin
                        r_state    <= POLL;
                        r_stat_req <= 1'b1;
                        r_busy     <= 1'b1;
                        r_wd_cnt   <= '0;
                    end
                end
                POLL: begin
                    if (stat_valid) begin
                        r_stat_q   <= stat4;
                        r_stat_req <= 1'b0;
                        r_state    <= ARB;
                    end else if (r_wd_cnt == WD_LAST) begin
                        r_stat_req    <= 1'b0;
                        r_timeout_err <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= IDLE;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                ARB: begin
                    if (!en) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_gnt_vld) begin
                        r_cmd_req <= 1'b1;
                        r_cmd4    <= slot_cmd(w_gnt_idx);
                        r_rr_ptr  <= w_gnt_idx + 2'd1;
                        r_wd_cnt  <= '0;
                        r_state   <= ISSUE;
                    end else begin
                        r_gap_cnt <= GAP_LOAD;
                        r_state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (!en) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_gap_cnt == '0) begin
                        r_stat_req <= 1'b1;
                        r_wd_cnt   <= '0;
                        r_state    <= POLL;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                ISSUE: begin
                    if (cmd_done) begin
                        r_cmd_req <= 1'b0;
                        r_cmd4    <= CMD_INVALID;
                        if (en) begin
                            r_stat_req <= 1'b1;
                            r_wd_cnt   <= '0;
                            r_state    <= POLL;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end else if (r_wd_cnt == WD_LAST) begin
                        r_cmd_req     <= 1'b0;
                        r_cmd4        <= CMD_INVALID;
                        r_timeout_err <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= IDLE;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                default: begin
                    r_stat_req <= 1'b0;
                    r_cmd_req  <= 1'b0;
                    r_cmd4     <= CMD_INVALID;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign stat_req    = r_stat_req;
    assign cmd_req     = r_cmd_req;
    assign cmd4        = r_cmd4;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_extio8x4_isched.sv
// Directed self-checking bench for extio8x4_isched with POLL_GAP=4, TIMEOUT=16.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_extio8x4_isched;

    logic       clk;
    logic       resetn;
    logic       en;
    logic       err_clr;
    logic       stat_req;
    logic       stat_valid;
    logic [3:0] stat4;
    logic       cmd_req;
    logic [3:0] cmd4;
    logic       cmd_done;
    logic [1:0] loc_rx_room;
    logic [1:0] loc_tx_pend;
    logic       busy;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    extio8x4_isched #(.POLL_GAP(4), .TIMEOUT(16)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .en          (en),
        .err_clr     (err_clr),
        .stat_req    (stat_req),
        .stat_valid  (stat_valid),
        .stat4       (stat4),
        .cmd_req     (cmd_req),
        .cmd4        (cmd4),
        .cmd_done    (cmd_done),
        .loc_rx_room (loc_rx_room),
        .loc_tx_pend (loc_tx_pend),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic e, input logic [3:0] st,
                                 input logic [1:0] rx, input logic [1:0] tx);
        en          = e;
        stat4       = st;
        loc_rx_room = rx;
        loc_tx_pend = tx;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkOutputBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic pulseStatValid();
        stat_valid = 1'b1;
        tick(1);
        stat_valid = 1'b0;
    endtask

    task automatic pulseCmdDone();
        cmd_done = 1'b1;
        tick(1);
        cmd_done = 1'b0;
    endtask

    logic [3:0] expCmd [5];

    initial begin
        expCmd = '{4'b0001, 4'b0000, 4'b0011, 4'b0010, 4'b0001};
        resetn = 1'b0;
        err_clr = 1'b0;
        stat_valid = 1'b0;
        cmd_done = 1'b0;
        applyStimulus(1'b0, 4'b1111, 2'b11, 2'b11);
        tick(3);
        checkOutputBit("rst_stat_req", stat_req, 1'b0);
        checkOutputBit("rst_cmd_req", cmd_req, 1'b0);
        checkOutput("rst_cmd4", cmd4, 4'b1111);
        checkOutputBit("rst_busy", busy, 1'b0);
        checkOutputBit("rst_timeout_err", timeout_err, 1'b0);
        resetn = 1'b1;
        tick(2);

        $display("[TB] empty polls");
        applyStimulus(1'b1, 4'b1111, 2'b11, 2'b11);
        tick(1);
        checkOutputBit("en_to_stat_req", stat_req, 1'b1);
        checkOutputBit("en_to_busy", busy, 1'b1);
        for (int r = 0; r < 2; r++) begin
            pulseStatValid();
            checkOutputBit("empty_req_drop", stat_req, 1'b0);
            tick(4);
            checkOutputBit("empty_gap_quiet", stat_req, 1'b0);
            checkOutputBit("empty_no_cmd", cmd_req, 1'b0);
            tick(1);
            checkOutputBit("empty_repoll", stat_req, 1'b1);
        end

        $display("[TB] round robin sequence");
        applyStimulus(1'b1, 4'b0000, 2'b11, 2'b11);
        for (int k = 0; k < 5; k++) begin
            pulseStatValid();
            tick(1);
            checkOutputBit("rr_cmd_req", cmd_req, 1'b1);
            checkOutput("rr_cmd4", cmd4, expCmd[k]);
            tick(2);
            pulseCmdDone();
            checkOutputBit("rr_done_cmd_req", cmd_req, 1'b0);
            checkOutputBit("rr_done_stat_req", stat_req, 1'b1);
            checkOutput("rr_done_cmd4", cmd4, 4'b1111);
        end

        $display("[TB] local gating");
        applyStimulus(1'b1, 4'b1110, 2'b00, 2'b11);
        pulseStatValid();
        tick(1);
        checkOutputBit("gate_no_grant", cmd_req, 1'b0);
        checkOutputBit("gate_busy", busy, 1'b1);
        loc_rx_room = 2'b01;
        tick(4);
        checkOutputBit("gate_repoll", stat_req, 1'b1);
        pulseStatValid();
        tick(1);
        checkOutputBit("gate_grant", cmd_req, 1'b1);
        checkOutput("gate_cmd4", cmd4, 4'b0001);
        tick(1);
        pulseCmdDone();
        checkOutputBit("gate_done_poll", stat_req, 1'b1);

        $display("[TB] poll watchdog");
        tick(15);
        checkOutputBit("wd_poll_held", stat_req, 1'b1);
        checkOutputBit("wd_poll_no_err", timeout_err, 1'b0);
        tick(1);
        checkOutputBit("wd_poll_err", timeout_err, 1'b1);
        checkOutputBit("wd_poll_req_drop", stat_req, 1'b0);
        checkOutputBit("wd_poll_busy", busy, 1'b0);
        tick(3);
        checkOutputBit("wd_err_stays_idle", stat_req, 1'b0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        checkOutputBit("wd_err_cleared", timeout_err, 1'b0);
        tick(1);
        checkOutputBit("wd_resume_poll", stat_req, 1'b1);

        $display("[TB] cmd_done at expiry");
        applyStimulus(1'b1, 4'b0000, 2'b11, 2'b11);
        pulseStatValid();
        tick(1);
        checkOutput("exp_cmd4", cmd4, 4'b0000);
        tick(15);
        checkOutputBit("exp_cmd_held", cmd_req, 1'b1);
        pulseCmdDone();
        checkOutputBit("exp_no_err", timeout_err, 1'b0);
        checkOutputBit("exp_next_poll", stat_req, 1'b1);
        checkOutputBit("exp_cmd_drop", cmd_req, 1'b0);

        $display("[TB] err_clr coinciding with expiry");
        tick(15);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        checkOutputBit("clr_tie_err_set", timeout_err, 1'b1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        checkOutputBit("clr_after_tie", timeout_err, 1'b0);
        tick(1);
        checkOutputBit("clr_tie_repoll", stat_req, 1'b1);

        $display("[TB] en dropped during issue");
        pulseStatValid();
        tick(1);
        checkOutput("endrop_cmd4", cmd4, 4'b0011);
        en = 1'b0;
        tick(3);
        checkOutputBit("endrop_held", cmd_req, 1'b1);
        checkOutputBit("endrop_busy", busy, 1'b1);
        pulseCmdDone();
        checkOutputBit("endrop_cmd_drop", cmd_req, 1'b0);
        checkOutput("endrop_cmd4_inv", cmd4, 4'b1111);
        checkOutputBit("endrop_idle", busy, 1'b0);
        checkOutputBit("endrop_no_poll", stat_req, 1'b0);

        $display("[TB] stray responses and async reset");
        pulseStatValid();
        pulseCmdDone();
        checkOutputBit("stray_busy", busy, 1'b0);
        checkOutputBit("stray_cmd_req", cmd_req, 1'b0);
        en = 1'b1;
        tick(1);
        checkOutputBit("areset_pre", stat_req, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        checkOutputBit("areset_stat_req", stat_req, 1'b0);
        checkOutputBit("areset_busy", busy, 1'b0);
        tick(1);
        resetn = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/extio8x4_isched.md
# extio8x4_isched

Initiator-side channel scheduler for the 8-bit-over-4-bit extio link. It polls the target's active-low FIFO status nibble through the initiator FSM and combines it with local buffer state. It then picks one of four transfer slots round-robin (read ch0, write ch0, read ch1, write ch1) and issues the matching 4-bit command to the initiator FSM, one transfer at a time. A watchdog guards both handshakes.

## Interface
Parameters:
- POLL_GAP, 16, idle cycles between a poll that finds nothing eligible and the next poll (>=1)
- TIMEOUT, 1024, max cycles stat_req or cmd_req may stay unanswered (>=2)

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- en  in  1  scheduler enable
- err_clr  in  1  clears timeout_err (pulse)
- stat_req  out  1  request status read from initiator FSM; held until stat_valid
- stat_valid  in  1  1-cycle pulse, stat4 valid
- stat4  in  4  target status, active-low: [0] rx0 data pending, [1] tx0 room, [2] rx1 data pending, [3] tx1 room
- cmd_req  out  1  request transfer; held until cmd_done
- cmd4  out  4  command nibble: {2'b00, ch, dir}, dir=1 target-to-initiator
- cmd_done  in  1  1-cycle pulse, transfer complete
- loc_rx_room  in  2  initiator has space for inbound byte on ch[1:0]
- loc_tx_pend  in  2  initiator holds outbound byte on ch[1:0]
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky watchdog flag

## Operation
- Slot k: 0=rd ch0 (cmd 4'b0001), 1=wr ch0 (4'b0000), 2=rd ch1 (4'b0011), 3=wr ch1 (4'b0010); cmd4 = {2'b00, k[1], ~k[0]}.
- elig[k] = ~stat_q[k] & local[k]; local = {loc_tx_pend[1], loc_rx_room[1], loc_tx_pend[0], loc_rx_room[0]}, sampled in ARB.
- Round-robin: search starts at rr_ptr and wraps 3->0; first eligible slot wins; rr_ptr <= winner+1 mod 4 (3 wraps to 0). rr_ptr holds when nothing is granted.
- States:
  - IDLE -> POLL when en & !timeout_err.
  - POLL: stat_req=1; on stat_valid capture stat_q <= stat4 -> ARB.
  - ARB (1 cycle): any elig -> ISSUE (register cmd4); none -> WAIT (gap_cnt <= POLL_GAP-1); !en -> IDLE.
  - WAIT: decrement gap_cnt; at 0 -> POLL; !en -> IDLE.
  - ISSUE: cmd_req=1, cmd4 stable; on cmd_done -> POLL if en, else IDLE.
- Status is always re-polled after each transfer; stat_q is never reused.
- en low during POLL or ISSUE: the handshake completes first (watchdog still active).
- Watchdog: wd_cnt clears on entry to POLL/ISSUE and increments each cycle there. At wd_cnt == TIMEOUT-1 with no response: drop req, set timeout_err, -> IDLE.
- stat_valid or cmd_done coinciding with expiry: the response wins, no error.
- While timeout_err=1 the block stays in IDLE. err_clr clears the flag; err_clr and expiry in the same cycle leave the flag set.
- stat_valid outside POLL and cmd_done outside ISSUE are ignored.

## Timing
- All outputs registered. Reset values: stat_req=0, cmd_req=0, cmd4=4'b1111 (invalid), busy=0, timeout_err=0; rr_ptr=0, stat_q=4'b1111, state=IDLE.
- en rises at cycle t in IDLE -> stat_req=1 at t+1.
- stat_valid at t -> ARB at t+1 -> cmd_req=1 and cmd4 valid at t+2.
- cmd_done at t -> cmd_req=0 at t+1, stat_req=1 at t+1.
- Empty poll: stat_valid at t -> stat_req=1 again at t+2+POLL_GAP.
- cmd4 returns to 4'b1111 when leaving ISSUE.
- Reset asserted mid-handshake: all outputs drop asynchronously to their reset values; the initiator FSM aborts its own sequence.

## Structure
- Package extio8x4_pkg:
  - state enum (IDLE, POLL, ARB, WAIT, ISSUE)
  - slot index constants
  - CMD_RD0/WR0/RD1/WR1 and CMD_INVALID=4'b1111
  - status bit positions
- Sub-module extio8x4_rr_arb4: combinational 4-way round-robin picker (elig[3:0], ptr[1:0] -> gnt_vld, gnt_idx[1:0]).

## Test plan
- Reset, en=1, stat4=4'b1111, all locals 1 -> polls repeat every POLL_GAP+2 cycles; cmd_req never asserts.
- stat4=4'b0000, locals all 1, cmd_done 3 cycles after each cmd_req -> cmd4 sequence 0001,0000,0011,0010,0001.
- stat4=4'b1110, loc_rx_room=2'b00 -> no grant; raise loc_rx_room[0] before the next ARB -> cmd4=0001.
- No stat_valid for TIMEOUT cycles -> timeout_err=1, stat_req=0, busy=0; err_clr -> POLL resumes.
- cmd_done exactly at watchdog expiry -> timeout_err stays 0, next state POLL.
- en dropped during ISSUE -> cmd_req held until cmd_done, then IDLE with cmd4=1111.
